// File: rtl/raman_pkg.sv
// Shared encodings for the Raman switch sequencer: mode values and FSM states.
package raman_pkg;

   localparam logic [1:0] MODE_CYCLE    = 2'b00;
   localparam logic [1:0] MODE_HOLD     = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SETTLE = 1'b1
   } seq_state_t;

endpackage

// File: rtl/switch_trig_detect.sv
// Scan-point compare against the acquisition counters plus rising-edge detect,
// giving one trig pulse per match episode.
module switch_trig_detect #(
   parameter int POINTS      = 10,
   parameter int MEASURES    = 100,
   parameter int TRIG_OFFSET = 50,
   parameter int MEAS_W      = 17,
   parameter int POINT_W     = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [MEAS_W-1:0]  cnt_measure,
   input  logic [POINT_W-1:0] cnt_point,
   output logic               trig
);

   // One extra bit so POINTS+TRIG_OFFSET cannot silently wrap the compare.
   localparam logic [POINT_W:0]  TRIG_POINT = (POINT_W+1)'(POINTS + TRIG_OFFSET);
   localparam logic [MEAS_W-1:0] LAST_MEAS  = MEAS_W'(MEASURES - 1);

   logic match;
   logic match_d;

   assign match = (cnt_measure == LAST_MEAS) && ({1'b0, cnt_point} == TRIG_POINT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) match_d <= 1'b0;
      else     match_d <= match;
   end

   assign trig = match & ~match_d & enable;

endmodule

// File: rtl/switch_sequencer.sv
// Optical switch sequencer: steps the switch once per scan trigger in cycle, hold or
// ping-pong mode, blanks data for a settle window and flags frame completion and overruns.
module switch_sequencer
   import raman_pkg::*;
#(
   parameter int POINTS        = 10,
   parameter int MEASURES      = 100,
   parameter int TRIG_OFFSET   = 50,
   parameter int CHANNELS      = 2,
   parameter int SETTLE_CYCLES = 64,
   parameter int MEAS_W        = 17,
   parameter int POINT_W       = 11,
   localparam int CH_W         = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [CH_W-1:0]     hold_ch,
   input  logic [MEAS_W-1:0]   cnt_measure,
   input  logic [POINT_W-1:0]  cnt_point,
   output logic [CH_W-1:0]     switch_sel,
   output logic [CHANNELS-1:0] switch_onehot,
   output logic                settling,
   output logic                frame_done,
   output logic                overrun,
   output logic [15:0]         switch_cnt
);

   localparam int             SC_W    = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
   localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

   logic trig;

   switch_trig_detect #(
      .POINTS      (POINTS),
      .MEASURES    (MEASURES),
      .TRIG_OFFSET (TRIG_OFFSET),
      .MEAS_W      (MEAS_W),
      .POINT_W     (POINT_W)
   ) u_trig (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .cnt_measure (cnt_measure),
      .cnt_point   (cnt_point),
      .trig        (trig)
   );

   seq_state_t          state, state_nx;
   logic [SC_W-1:0]     settle_cnt, settle_cnt_nx;
   logic                pp_up, pp_up_nx;
   logic [CH_W-1:0]     sel_nx;
   logic [CHANNELS-1:0] onehot_nx;
   logic                settling_nx, frame_done_nx, overrun_nx;
   logic [15:0]         switch_cnt_nx;
   logic [CH_W-1:0]     cand;
   logic                cand_up;

   // Candidate channel for a trigger now; cand_up is the ping-pong direction afterwards.
   // Non-ping-pong triggers leave the direction "up" so entering ping-pong starts upward.
   always_comb begin
      cand    = switch_sel;
      cand_up = 1'b1;
      case (mode)
         MODE_CYCLE: cand = (switch_sel == LAST_CH) ? '0 : switch_sel + 1'b1;
         MODE_PINGPONG: begin
            if (pp_up) begin
               if (switch_sel == LAST_CH) begin
                  cand    = switch_sel - 1'b1;
                  cand_up = 1'b0;
               end else begin
                  cand    = switch_sel + 1'b1;
               end
            end else begin
               if (switch_sel == '0) begin
                  cand    = CH_W'(1);
               end else begin
                  cand    = switch_sel - 1'b1;
                  cand_up = 1'b0;
               end
            end
         end
         default: cand = (hold_ch > LAST_CH) ? LAST_CH : hold_ch;
      endcase
   end

   always_comb begin
      state_nx      = state;
      settle_cnt_nx = settle_cnt;
      pp_up_nx      = pp_up;
      sel_nx        = switch_sel;
      onehot_nx     = switch_onehot;
      settling_nx   = settling;
      frame_done_nx = 1'b0;
      overrun_nx    = overrun;
      switch_cnt_nx = switch_cnt;
      case (state)
         ST_RUN: begin
            if (trig) begin
               pp_up_nx = cand_up;
               if (cand != switch_sel) begin
                  sel_nx        = cand;
                  onehot_nx     = CHANNELS'(1) << cand;
                  switch_cnt_nx = switch_cnt + 16'd1;
                  frame_done_nx = (cand == '0) &&
                                  ((mode == MODE_CYCLE) || (mode == MODE_PINGPONG));
                  if (SETTLE_CYCLES != 0) begin
                     state_nx      = ST_SETTLE;
                     settling_nx   = 1'b1;
                     settle_cnt_nx = SC_LOAD;
                  end
               end
            end
         end
         ST_SETTLE: begin
            if (trig) overrun_nx = 1'b1;
            if (settle_cnt == '0) begin
               state_nx    = ST_RUN;
               settling_nx = 1'b0;
            end else begin
               settle_cnt_nx = settle_cnt - 1'b1;
            end
         end
         default: state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_RUN;
         settle_cnt    <= '0;
         pp_up         <= 1'b1;
         switch_sel    <= '0;
         switch_onehot <= CHANNELS'(1);
         settling      <= 1'b0;
         frame_done    <= 1'b0;
         overrun       <= 1'b0;
         switch_cnt    <= '0;
      end else begin
         state         <= state_nx;
         settle_cnt    <= settle_cnt_nx;
         pp_up         <= pp_up_nx;
         switch_sel    <= sel_nx;
         switch_onehot <= onehot_nx;
         settling      <= settling_nx;
         frame_done    <= frame_done_nx;
         overrun       <= overrun_nx;
         switch_cnt    <= switch_cnt_nx;
      end
   end

endmodule

// File: tb/tb_switch_sequencer.sv
// Bench for switch_sequencer: three instances (2, 3 and 4 channels) share stimulus; a
// queue-based reference model predicts every channel change and a monitor checks it.
module tb_switch_sequencer;
   import raman_pkg::*;

   localparam int SETTLE = 64;
   localparam int NCH [3] = '{2, 3, 4};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [1:0]  mode = MODE_CYCLE;
   logic [1:0]  hold_ch = 2'd0;
   logic [16:0] cnt_measure = 17'd0;
   logic [10:0] cnt_point = 11'd0;

   logic        sel0;
   logic [1:0]  sel1, sel2;
   logic [1:0]  oh0;
   logic [2:0]  oh1;
   logic [3:0]  oh2;
   logic        st0, st1, st2, fd0, fd1, fd2, ov0, ov1, ov2;
   logic [15:0] cn0, cn1, cn2;

   switch_sequencer #(.CHANNELS(2)) u0 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .hold_ch(hold_ch[0]),
      .cnt_measure(cnt_measure), .cnt_point(cnt_point), .switch_sel(sel0),
      .switch_onehot(oh0), .settling(st0), .frame_done(fd0), .overrun(ov0), .switch_cnt(cn0));
   switch_sequencer #(.CHANNELS(3)) u1 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .hold_ch(hold_ch),
      .cnt_measure(cnt_measure), .cnt_point(cnt_point), .switch_sel(sel1),
      .switch_onehot(oh1), .settling(st1), .frame_done(fd1), .overrun(ov1), .switch_cnt(cn1));
   switch_sequencer #(.CHANNELS(4)) u2 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .hold_ch(hold_ch),
      .cnt_measure(cnt_measure), .cnt_point(cnt_point), .switch_sel(sel2),
      .switch_onehot(oh2), .settling(st2), .frame_done(fd2), .overrun(ov2), .switch_cnt(cn2));

   logic [1:0]  sel_a [3];
   logic [3:0]  oh_a  [3];
   logic        st_a  [3];
   logic        fd_a  [3];
   logic        ov_a  [3];
   logic [15:0] cn_a  [3];
   assign sel_a[0] = {1'b0, sel0};  assign sel_a[1] = sel1;          assign sel_a[2] = sel2;
   assign oh_a[0]  = {2'b00, oh0};  assign oh_a[1]  = {1'b0, oh1};   assign oh_a[2]  = oh2;
   assign st_a[0]  = st0;  assign st_a[1] = st1;  assign st_a[2] = st2;
   assign fd_a[0]  = fd0;  assign fd_a[1] = fd1;  assign fd_a[2] = fd2;
   assign ov_a[0]  = ov0;  assign ov_a[1] = ov1;  assign ov_a[2] = ov2;
   assign cn_a[0]  = cn0;  assign cn_a[1] = cn1;  assign cn_a[2] = cn2;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int k, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d (CHANNELS=%0d) at cycle %0d: got %0d expected %0d",
                  name, k, NCH[k], cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Expected entry per change: {sel[1:0], frame_done, switch_cnt[15:0]}
   logic [18:0] exp_q0[$], exp_q1[$], exp_q2[$];
   int          m_cur [3], m_cnt [3], m_busy [3], m_phase [3];
   bit          m_ovr [3];
   logic [1:0]  m_prevmode [3];
   bit          prev_match = 1'b0;

   function automatic void push_exp(input int k, input logic [18:0] v);
      case (k)
         0: exp_q0.push_back(v);
         1: exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endfunction

   function automatic int q_size(input int k);
      case (k)
         0: return exp_q0.size();
         1: return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [18:0] pop_exp(input int k);
      case (k)
         0: return exp_q0.pop_front();
         1: return exp_q1.pop_front();
         default: return exp_q2.pop_front();
      endcase
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_cur[k] = 0; m_cnt[k] = 0; m_busy[k] = 0; m_phase[k] = 0;
         m_ovr[k] = 1'b0; m_prevmode[k] = MODE_CYCLE;
      end
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
   endfunction

   // Ping-pong is a position in the bounce sequence 0,1..N-1..1 of period 2N-2.
   function automatic void model_trig(input int k);
      int n, nxt, hc, per;
      bit fd;
      n = NCH[k];
      if (cyc < m_busy[k]) begin
         m_ovr[k] = 1'b1;
         return;
      end
      hc  = (n == 2) ? int'(hold_ch[0]) : int'(hold_ch);
      per = 2 * n - 2;
      if (mode == MODE_CYCLE) begin
         nxt = (m_cur[k] + 1) % n;
      end else if (mode == MODE_PINGPONG) begin
         if (m_prevmode[k] != MODE_PINGPONG) m_phase[k] = m_cur[k];
         m_phase[k] = (m_phase[k] + 1) % per;
         nxt = (m_phase[k] < n) ? m_phase[k] : per - m_phase[k];
      end else begin
         nxt = (hc < n - 1) ? hc : n - 1;
      end
      m_prevmode[k] = mode;
      if (nxt != m_cur[k]) begin
         fd = (nxt == 0) && (mode == MODE_CYCLE || mode == MODE_PINGPONG);
         m_cnt[k] = (m_cnt[k] + 1) % 65536;
         push_exp(k, {2'(nxt), fd, 16'(m_cnt[k])});
         m_busy[k] = cyc + 1 + SETTLE;
         m_cur[k] = nxt;
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input bit m);
      @(posedge clk);
      #1;
      if (m) begin
         cnt_measure = 17'd99;
         cnt_point   = 11'd60;
      end else begin
         cnt_measure = 17'($urandom_range(0, 200));
         if ($urandom_range(0, 3) == 0) cnt_measure = 17'd99;
         cnt_point   = 11'($urandom_range(0, 100));
         if (cnt_measure == 17'd99 && cnt_point == 11'd60) cnt_point = 11'd61;
      end
      if (m && !prev_match && enable)
         for (int k = 0; k < 3; k++) model_trig(k);
      prev_match = m;
   endtask

   task automatic pulse(input int len, input int gap);
      repeat (len) step(1'b1);
      repeat (gap) step(1'b0);
   endtask

   task automatic check_quiet(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_sel"}, k, sel_a[k], m_cur[k]);
         chk({tag, "_onehot"}, k, oh_a[k], 4'(1) << m_cur[k]);
         chk({tag, "_settling"}, k, st_a[k], 0);
         chk({tag, "_frame_done"}, k, fd_a[k], 0);
         chk({tag, "_overrun"}, k, ov_a[k], m_ovr[k]);
         chk({tag, "_switch_cnt"}, k, cn_a[k], m_cnt[k]);
      end
   endtask

   // Asserted between clock edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      cnt_measure = 17'd0;
      cnt_point   = 11'd0;
      prev_match  = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         chk("rst_sel", k, sel_a[k], 0);
         chk("rst_onehot", k, oh_a[k], 1);
         chk("rst_settling", k, st_a[k], 0);
         chk("rst_frame_done", k, fd_a[k], 0);
         chk("rst_overrun", k, ov_a[k], 0);
         chk("rst_switch_cnt", k, cn_a[k], 0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [15:0] mon_prev_cnt [3];
   logic [1:0]  mon_sel [3];
   bit          mon_prev_st [3];
   int          mon_st_len [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            mon_prev_cnt[k] = '0;
            mon_sel[k] = '0;
            mon_prev_st[k] = 1'b0;
            mon_st_len[k] = 0;
         end else begin
            logic [18:0] e;
            bit changed;
            changed = (cn_a[k] != mon_prev_cnt[k]);
            if (changed) begin
               if (q_size(k) == 0) begin
                  chk("unexpected_change", k, cn_a[k], mon_prev_cnt[k]);
               end else begin
                  e = pop_exp(k);
                  mon_sel[k] = e[18:17];
                  chk("chg_sel", k, sel_a[k], e[18:17]);
                  chk("chg_frame_done", k, fd_a[k], e[16]);
                  chk("chg_switch_cnt", k, cn_a[k], e[15:0]);
                  chk("chg_settling", k, st_a[k], 1);
               end
            end else begin
               chk("hold_sel", k, sel_a[k], mon_sel[k]);
               chk("hold_frame_done", k, fd_a[k], 0);
            end
            chk("onehot", k, oh_a[k], 4'(1) << sel_a[k]);
            if (st_a[k] && !mon_prev_st[k]) chk("settle_start_on_change", k, changed, 1);
            if (st_a[k]) begin
               mon_st_len[k]++;
            end else if (mon_st_len[k] != 0) begin
               chk("settle_len", k, mon_st_len[k], SETTLE);
               mon_st_len[k] = 0;
            end
            mon_prev_st[k] = st_a[k];
            mon_prev_cnt[k] = cn_a[k];
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) step(1'b0);
      check_quiet("reset_state");

      // Cycle mode, three well-spaced single-cycle matches
      mode = MODE_CYCLE;
      repeat (3) pulse(1, 100);
      check_quiet("cycle");

      // Match held for 500 clocks: one change only
      do_reset();
      pulse(500, 100);
      check_quiet("held_match");

      // Ping-pong from channel 0
      do_reset();
      mode = MODE_PINGPONG;
      repeat (8) pulse(1, $urandom_range(70, 120));
      check_quiet("pingpong");

      // Hold with out-of-range target, then repeated trigger
      do_reset();
      mode = MODE_HOLD;
      hold_ch = 2'd3;
      repeat (2) pulse(1, 100);
      check_quiet("hold");

      // Trigger during settle: ignored, overrun sticky; boundary at 63/64-cycle gaps
      do_reset();
      mode = MODE_CYCLE;
      pulse(1, 19);
      pulse(1, 100);
      check_quiet("overrun");
      pulse(1, 63);
      pulse(1, 64);
      pulse(1, 100);
      check_quiet("overrun_boundary");

      // Async reset mid-settle, then disabled triggers
      pulse(1, 10);
      do_reset();
      enable = 1'b0;
      pulse(1, 30);
      pulse(1, 80);
      check_quiet("disabled");
      enable = 1'b1;
      pulse(1, 5);
      enable = 1'b0;
      pulse(1, 100);
      enable = 1'b1;
      check_quiet("disable_mid_settle");

      // Randomised mix of modes, targets, enable and spacing
      repeat (60) begin
         mode    = 2'($urandom_range(0, 3));
         hold_ch = 2'($urandom_range(0, 3));
         enable  = ($urandom_range(0, 9) != 0);
         pulse($urandom_range(1, 3), $urandom_range(3, 140));
      end
      enable = 1'b1;
      repeat (100) step(1'b0);
      check_quiet("random");

      for (int k = 0; k < 3; k++) chk("queue_drained", k, q_size(k), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog: the sequence above is far shorter than this
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
